// File: rtl/packet_dispenser_if.sv
// rtl/packet_dispenser_if.sv - handshake/bus bundle between packet_dispenser and its host, RAM and consumers
//
// Signals:
//   done_writing  host -> dispenser, one-cycle pulse: table loaded
//   pkt_count     host -> dispenser, packets in table (sampled with done_writing)
//   serve_req     consumers -> dispenser, per-module level request
//   mem_data      RAM -> dispenser, read data one cycle after mem_addr/mem_rd
//   mem_addr      dispenser -> RAM, byte address
//   mem_rd        dispenser -> RAM, read strobe
//   addr_select   dispenser -> RAM mux, 1 = host writer owns the port, 0 = dispenser
//   out_of_data   dispenser -> host, no undelivered packets remain
//   reg_en        dispenser -> consumers, one-hot load strobe
//   pkt_out       dispenser -> consumers, assembled packet (word 0 in the low bits)
// Modports: master = environment side, slave = packet_dispenser side.
interface packet_dispenser_if #(
  parameter int NUM_MODS      = 4,
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_PKT = 6,
  parameter int NUM_PKTS      = 64
);
  localparam int P  = WORDS_PER_PKT * WORD_W;
  localparam int CW = $clog2(NUM_PKTS + 1);

  logic                done_writing;
  logic [CW-1:0]       pkt_count;
  logic [NUM_MODS-1:0] serve_req;
  logic [WORD_W-1:0]   mem_data;
  logic [31:0]         mem_addr;
  logic                mem_rd;
  logic [1:0]          addr_select;
  logic                out_of_data;
  logic [NUM_MODS-1:0] reg_en;
  logic [P-1:0]        pkt_out;

  modport master (
    output done_writing, pkt_count, serve_req, mem_data,
    input  mem_addr, mem_rd, addr_select, out_of_data, reg_en, pkt_out
  );

  modport slave (
    input  done_writing, pkt_count, serve_req, mem_data,
    output mem_addr, mem_rd, addr_select, out_of_data, reg_en, pkt_out
  );
endinterface

// File: rtl/packet_dispenser.sv
// rtl/packet_dispenser.sv - streams fixed-size packets from the input RAM to arbitrated consumer modules
//
// Ports:
//   clock    single clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      packet_dispenser_if.slave (host pulse/count, requests, RAM read port, grants, packet)
// Build option:
//   RR_ARB_EN  defined   -> round-robin arbitration, search starts after the last granted module
//              undefined -> fixed priority, lowest requesting index wins
module packet_dispenser #(
  parameter int          NUM_MODS      = 4,
  parameter int          WORD_W        = 32,
  parameter int          WORDS_PER_PKT = 6,
  parameter int          NUM_PKTS      = 64,
  parameter logic [31:0] BASE_ADDR     = 32'd0
) (
  input logic              clock,
  input logic              reset_n,
  packet_dispenser_if.slave bus
);
  localparam int P   = WORDS_PER_PKT * WORD_W;
  localparam int CW  = $clog2(NUM_PKTS + 1);
  localparam int WCW = $clog2(WORDS_PER_PKT + 1);
  localparam int GW  = (NUM_MODS > 1) ? $clog2(NUM_MODS) : 1;

  typedef enum logic [2:0] {IDLE, READY, FETCH, LAST, GRANT} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_pkt_idx;
  logic [WCW-1:0]      r_word_cnt;   // words already issued for the current packet
  logic [29:0]         r_next_word;  // running pkt_idx*WORDS_PER_PKT+word_cnt, no multiplier
  logic [GW-1:0]       r_grant;
  logic                r_rd;
  logic                r_rd_q;
  logic [31:0]         r_addr;
  logic [P-1:0]        r_pkt;
  logic [NUM_MODS-1:0] r_reg_en;
  logic                r_out_of_data;
  logic [1:0]          r_addr_select;
  logic [GW-1:0]       w_win;
  logic                w_any;

`ifdef RR_ARB_EN
  logic [GW-1:0] r_rr_ptr;  // index where the next search starts

  always_comb begin
    int j;
    w_win = '0;
    w_any = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_MODS; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_MODS) j = j - NUM_MODS;
      if (!w_any && bus.serve_req[j]) begin
        w_any = 1'b1;
        w_win = GW'(j);
      end
    end
  end
`else
  // Walk downwards so the lowest set index is the last one written.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = NUM_MODS - 1; k >= 0; k--) begin
      if (bus.serve_req[k]) begin
        w_any = 1'b1;
        w_win = GW'(k);
      end
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_pkt_idx     <= '0;
      r_word_cnt    <= '0;
      r_next_word   <= '0;
      r_grant       <= '0;
      r_rd          <= 1'b0;
      r_rd_q        <= 1'b0;
      r_addr        <= BASE_ADDR;
      r_pkt         <= '0;
      r_reg_en      <= '0;
      r_out_of_data <= 1'b1;
      r_addr_select <= 2'd1;
`ifdef RR_ARB_EN
      r_rr_ptr      <= '0;
`endif
    end else begin
      // RAM data lags the strobe by one cycle; shift words in from the top
      // so word 0 ends up in the low bits after the last one arrives.
      r_rd_q   <= r_rd;
      if (r_rd_q)
        r_pkt <= (r_pkt >> WORD_W) | (P'(bus.mem_data) << (P - WORD_W));
      r_reg_en <= '0;

      case (r_state)
        IDLE: begin
          if (bus.done_writing && (bus.pkt_count != '0)) begin
            r_count       <= (bus.pkt_count > CW'(NUM_PKTS)) ? CW'(NUM_PKTS) : bus.pkt_count;
            r_pkt_idx     <= '0;
            r_next_word   <= '0;
            r_out_of_data <= 1'b0;
            r_addr_select <= 2'd0;
            r_state       <= READY;
          end
        end
        READY: begin
          if (w_any) begin
            r_grant     <= w_win;
            r_rd        <= 1'b1;
            r_addr      <= {r_next_word, 2'b00} + BASE_ADDR;
            r_next_word <= r_next_word + 30'd1;
            r_word_cnt  <= WCW'(1);
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          if (r_word_cnt == WCW'(WORDS_PER_PKT)) begin
            r_rd    <= 1'b0;
            r_state <= LAST;
          end else begin
            r_addr      <= {r_next_word, 2'b00} + BASE_ADDR;
            r_next_word <= r_next_word + 30'd1;
            r_word_cnt  <= r_word_cnt + WCW'(1);
          end
        end
        LAST: begin
          r_reg_en <= NUM_MODS'(1) << r_grant;
          r_state  <= GRANT;
        end
        GRANT: begin
          r_pkt_idx <= r_pkt_idx + CW'(1);
`ifdef RR_ARB_EN
          r_rr_ptr  <= (r_grant == GW'(NUM_MODS - 1)) ? '0 : r_grant + GW'(1);
`endif
          if ((r_pkt_idx + CW'(1)) == r_count) begin
            r_out_of_data <= 1'b1;
            r_addr_select <= 2'd1;
            r_state       <= IDLE;
          end else begin
            r_state <= READY;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr    = r_addr;
  assign bus.mem_rd      = r_rd;
  assign bus.addr_select = r_addr_select;
  assign bus.out_of_data = r_out_of_data;
  assign bus.reg_en      = r_reg_en;
  assign bus.pkt_out     = r_pkt;
endmodule
